// File: rtl/rvv_backend_pmtrdt_rs.sv
// Reservation station for the PMTRDT path: circular buffer with multi-lane push/pop
// and a full oldest-first window export for look-ahead by the execution units.
package rvv_pmtrdt_pkg;
    localparam int PMTRDT_RS_DEPTH = 8;
    localparam int NUM_PMTRDT      = 2;

    typedef struct packed {
        logic [7:0] tag;
        logic [4:0] vd;
        logic [2:0] funct3;
    } PMT_RDT_RS_t;
endpackage

module rvv_backend_pmtrdt_rs
    import rvv_pmtrdt_pkg::*;
#(
    parameter int DEPTH    = PMTRDT_RS_DEPTH,
    parameter int PUSH_NUM = 2,
    parameter int POP_NUM  = NUM_PMTRDT,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic        [PUSH_NUM-1:0]        push_valid_dp2rs,
    input  PMT_RDT_RS_t [PUSH_NUM-1:0]        push_data_dp2rs,
    output logic        [PUSH_NUM-1:0]        push_ready_rs2dp,
    input  logic        [POP_NUM-1:0]         pop_ex2rs,
    output PMT_RDT_RS_t [POP_NUM-1:0]         pmtrdt_uop_rs2ex,
    output logic                              fifo_empty_rs2ex,
    output logic        [POP_NUM-1:0]         fifo_almost_empty_rs2ex,
    output PMT_RDT_RS_t [DEPTH-1:0]           all_uop_data,
    output logic        [CW-1:0]              all_uop_cnt,
    input  logic                              trap_flush_rvv
);

    PMT_RDT_RS_t [DEPTH-1:0] mem;
    logic [AW-1:0]           wptr, rptr;
    logic [CW-1:0]           cnt, free, n_push, n_pop;
    logic [PUSH_NUM-1:0]     push_acc;

    assign free     = CW'(DEPTH) - cnt;
    assign push_acc = push_valid_dp2rs & push_ready_rs2dp;

    // Ready looks only at registered occupancy; same-cycle pops never free space.
    for (genvar i = 0; i < PUSH_NUM; i++) begin : g_ready
        assign push_ready_rs2dp[i] = free > CW'(i);
    end

    for (genvar i = 0; i < POP_NUM; i++) begin : g_pop_lane
        assign fifo_almost_empty_rs2ex[i] = cnt <= CW'(i);
        assign pmtrdt_uop_rs2ex[i]        = mem[rptr + AW'(i)];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_window
        assign all_uop_data[k] = mem[rptr + AW'(k)];
    end

    assign fifo_empty_rs2ex = cnt == '0;
    assign all_uop_cnt      = cnt;

    always_comb begin
        n_push = '0;
        n_pop  = '0;
        for (int i = 0; i < PUSH_NUM; i++) n_push = n_push + CW'(push_acc[i]);
        for (int i = 0; i < POP_NUM; i++)  n_pop  = n_pop + CW'(pop_ex2rs[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (trap_flush_rvv) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + n_push[AW-1:0];
            rptr <= rptr + n_pop[AW-1:0];
            cnt  <= cnt + n_push - n_pop;
        end
    end

    // Entry storage carries no reset; lanes index wptr+lane so wrap is per lane.
    always_ff @(posedge clk) begin
        if (!trap_flush_rvv) begin
            for (int i = 0; i < PUSH_NUM; i++) begin
                if (push_acc[i]) mem[wptr + AW'(i)] <= push_data_dp2rs[i];
            end
        end
    end

    a_push_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (push_valid_dp2rs & (push_valid_dp2rs + PUSH_NUM'(1))) == '0);
    a_pop_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_ex2rs & (pop_ex2rs + POP_NUM'(1))) == '0);
    a_pop_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_ex2rs & fifo_almost_empty_rs2ex) == '0);

endmodule

// File: tb/tb_rvv_backend_pmtrdt_rs.sv
// Directed bench for the PMTRDT reservation station (DEPTH=8, 2 push / 2 pop lanes).
module tb_rvv_backend_pmtrdt_rs;
    import rvv_pmtrdt_pkg::*;

    localparam int DEPTH = 8;
    localparam int PN    = 2;
    localparam int QN    = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic        [PN-1:0]    push_valid;
    PMT_RDT_RS_t [PN-1:0]    push_data;
    logic        [PN-1:0]    push_ready;
    logic        [QN-1:0]    pop;
    PMT_RDT_RS_t [QN-1:0]    uop;
    logic                    empty;
    logic        [QN-1:0]    aempty;
    PMT_RDT_RS_t [DEPTH-1:0] all_data;
    logic        [3:0]       all_cnt;
    logic                    flush;

    int checks = 0;
    int errors = 0;

    rvv_backend_pmtrdt_rs #(.DEPTH(DEPTH), .PUSH_NUM(PN), .POP_NUM(QN)) u_dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .push_valid_dp2rs        (push_valid),
        .push_data_dp2rs         (push_data),
        .push_ready_rs2dp        (push_ready),
        .pop_ex2rs               (pop),
        .pmtrdt_uop_rs2ex        (uop),
        .fifo_empty_rs2ex        (empty),
        .fifo_almost_empty_rs2ex (aempty),
        .all_uop_data            (all_data),
        .all_uop_cnt             (all_cnt),
        .trap_flush_rvv          (flush)
    );

    always #5 clk = ~clk;

    function automatic PMT_RDT_RS_t mk(input logic [7:0] t);
        PMT_RDT_RS_t u;
        u.tag    = t;
        u.vd     = t[4:0];
        u.funct3 = t[2:0];
        return u;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [1:0] p);
        push_valid   = v;
        push_data[0] = mk(t0);
        push_data[1] = mk(t1);
        pop          = p;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        #12;
        chk("rst_cnt",    32'(all_cnt),    32'd0);
        chk("rst_empty",  32'(empty),      32'd1);
        chk("rst_aempty", 32'(aempty),     32'b11);
        chk("rst_ready",  32'(push_ready), 32'b11);
        rst_n = 1'b1;
        step();

        // single push
        drive(2'b01, 8'hA1, 8'h00, 2'b00);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("one_cnt",    32'(all_cnt),    32'd1);
        chk("one_empty",  32'(empty),      32'd0);
        chk("one_aempty", 32'(aempty),     32'b10);
        chk("one_uop0",   32'(uop[0].tag), 32'hA1);
        chk("one_vd",     32'(uop[0].vd),  32'h01);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("one_pop_cnt", 32'(all_cnt), 32'd0);

        // fill to full from rptr=wptr=1
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 8'(8'h10 + 2*c), 8'(8'h11 + 2*c), 2'b00);
            step();
            chk("fill_cnt", 32'(all_cnt), 32'(2*c + 2));
        end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("full_ready",  32'(push_ready), 32'b00);
        chk("full_aempty", 32'(aempty),     32'b00);
        for (int k = 0; k < DEPTH; k++)
            chk("full_data", 32'(all_data[k].tag), 32'(8'h10 + k));
        drive(2'b11, 8'h20, 8'h21, 2'b00);
        step();
        chk("over_cnt",   32'(all_cnt),          32'd8);
        chk("over_data7", 32'(all_data[7].tag),  32'h17);
        chk("over_data0", 32'(all_data[0].tag),  32'h10);

        // full with simultaneous push and pop
        drive(2'b11, 8'h30, 8'h31, 2'b11);
        step();
        chk("fpp_cnt",   32'(all_cnt),     32'd6);
        chk("fpp_ready", 32'(push_ready),  32'b11);
        chk("fpp_uop0",  32'(uop[0].tag),  32'h12);
        chk("fpp_uop1",  32'(uop[1].tag),  32'h13);
        drive(2'b11, 8'h30, 8'h31, 2'b00);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("fpp2_cnt", 32'(all_cnt),         32'd8);
        chk("fpp2_d5",  32'(all_data[5].tag), 32'h17);
        chk("fpp2_d6",  32'(all_data[6].tag), 32'h30);
        chk("fpp2_d7",  32'(all_data[7].tag), 32'h31);

        // drain: rptr=wptr=3, cnt=0
        for (int c = 0; c < 4; c++) begin
            drive(2'b00, 8'h00, 8'h00, 2'b11);
            step();
        end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("drain_empty", 32'(empty), 32'd1);

        // move pointers to 7
        drive(2'b11, 8'h70, 8'h71, 2'b00);
        step();
        drive(2'b11, 8'h72, 8'h73, 2'b11);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b11);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("pre_wrap_cnt", 32'(all_cnt), 32'd0);

        // wraparound: entries at 7 and 0
        drive(2'b11, 8'h40, 8'h41, 2'b00);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("wrap_cnt",  32'(all_cnt),         32'd2);
        chk("wrap_uop0", 32'(uop[0].tag),      32'h40);
        chk("wrap_uop1", 32'(uop[1].tag),      32'h41);
        chk("wrap_d1",   32'(all_data[1].tag), 32'h41);
        drive(2'b00, 8'h00, 8'h00, 2'b01);
        step();
        chk("wrap_pop1_uop0", 32'(uop[0].tag), 32'h41);
        chk("wrap_pop1_cnt",  32'(all_cnt),    32'd1);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("wrap_pop2_cnt", 32'(all_cnt), 32'd0);

        // flush priority at cnt=5
        drive(2'b11, 8'h50, 8'h51, 2'b00);
        step();
        drive(2'b11, 8'h52, 8'h53, 2'b00);
        step();
        drive(2'b01, 8'h54, 8'h00, 2'b00);
        step();
        chk("pre_flush_cnt", 32'(all_cnt), 32'd5);
        drive(2'b11, 8'h55, 8'h56, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("flush_cnt",    32'(all_cnt),    32'd0);
        chk("flush_empty",  32'(empty),      32'd1);
        chk("flush_ready",  32'(push_ready), 32'b11);
        chk("flush_aempty", 32'(aempty),     32'b11);
        drive(2'b01, 8'h60, 8'h00, 2'b00);
        step();
        chk("post_flush_uop0", 32'(uop[0].tag), 32'h60);
        chk("post_flush_cnt",  32'(all_cnt),    32'd1);

        // async reset mid-stream at cnt=3
        drive(2'b11, 8'h61, 8'h62, 2'b00);
        step();
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        chk("pre_arst_cnt", 32'(all_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",    32'(all_cnt),    32'd0);
        chk("arst_empty",  32'(empty),      32'd1);
        chk("arst_aempty", 32'(aempty),     32'b11);
        chk("arst_ready",  32'(push_ready), 32'b11);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_hold_cnt", 32'(all_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rvv_backend_pmtrdt_rs.md
# rvv_backend_pmtrdt_rs

Reservation station for the permutation/reduction/compare (PMTRDT) execution path. It sits between dispatch and the PMTRDT execution wrapper. It accepts up to `PUSH_NUM` uops per cycle from dispatch into a circular buffer. It presents the oldest `POP_NUM` uops to the PMTRDT units and retires them on their pop strobes. It also exports the full occupied window (`all_uop_data`, `all_uop_cnt`) so units can look ahead at queued uops, for example for multi-uop permutation or reduction sequences.

## Interface
- `DEPTH`, default `PMTRDT_RS_DEPTH` (8): entry count; must be a power of two and ≥ `PUSH_NUM`, `POP_NUM`.
- `PUSH_NUM`, default 2: dispatch lanes per cycle.
- `POP_NUM`, default `NUM_PMTRDT`: execution-side pop lanes.

- `clk`  in  1  the single clock for the block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `push_valid_dp2rs`  in  `PUSH_NUM`  lane push request; bits must be low-justified (contiguous from bit 0).
- `push_data_dp2rs`  in  `PMT_RDT_RS_t[PUSH_NUM]`  uop per push lane.
- `push_ready_rs2dp`  out  `PUSH_NUM`  bit i = 1 iff free entries > i.
- `pop_ex2rs`  in  `POP_NUM`  pop strobe per lane; low-justified.
- `pmtrdt_uop_rs2ex`  out  `PMT_RDT_RS_t[POP_NUM]`  lane i = entry at read pointer + i.
- `fifo_empty_rs2ex`  out  1  occupancy == 0.
- `fifo_almost_empty_rs2ex`  out  `POP_NUM`  bit i = 1 iff occupancy ≤ i (bit 0 equals `fifo_empty_rs2ex`).
- `all_uop_data`  out  `PMT_RDT_RS_t[DEPTH]`  index k = entry at read pointer + k; oldest first.
- `all_uop_cnt`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `trap_flush_rvv`  in  1  discard all entries.

## Operation
- **Storage**
  - `DEPTH` entry registers.
  - Write pointer and read pointer, each `$clog2(DEPTH)` bits; they wrap modulo `DEPTH`.
  - Occupancy counter `cnt`, `$clog2(DEPTH)+1` bits.
  - Entry data is not reset.
- **Push**
  - Lane i is accepted when `push_valid_dp2rs[i] & push_ready_rs2dp[i]`.
  - Accepted lanes write entries wptr+0..n-1 in lane order; wptr advances by n = number of accepted lanes.
  - Ready is computed from current `cnt` only. Same-cycle pops do not free space for same-cycle pushes.
- **Pop**
  - n_pop = number of set `pop_ex2rs` bits; rptr advances by n_pop.
  - Popping lane i while `fifo_almost_empty_rs2ex[i]` = 1 is illegal. Assert it; RTL behaviour is undefined.
- **Count**
  - `cnt_next = cnt + n_push - n_pop` on every edge without flush.
- **Flush**
  - `trap_flush_rvv` = 1 at an edge sets wptr = rptr = cnt = 0.
  - Pushes and pops in that cycle are discarded.
  - Flush has priority over all other events.
- **Window outputs**
  - `all_uop_data[k]` for k ≥ `all_uop_cnt` is don't-care: stale contents, no zeroing.
  - `pmtrdt_uop_rs2ex[i]` is valid only when `fifo_almost_empty_rs2ex[i]` = 0.
- **Non-contiguous valid or pop bits:** protocol violation; assert.

## Timing
- Reset values:
  - pointers and `cnt` = 0
  - `fifo_empty_rs2ex` = 1
  - `fifo_almost_empty_rs2ex` = all 1
  - `push_ready_rs2dp` = all 1
  - `all_uop_cnt` = 0
  - data outputs don't-care
- All outputs are combinational from registered state (pointers, `cnt`, entries). There is no input-to-output combinational path.
- Latency is 1 cycle: a uop pushed at edge N appears on `pmtrdt_uop_rs2ex` / `all_uop_data` after edge N. There is no empty-bypass.
- Full (`cnt` = `DEPTH`): `push_ready_rs2dp` = 0. A simultaneous pop still retires entries, and ready rises the next cycle.
- Pointer wrap: writing or reading across index `DEPTH-1` → 0 within one cycle is handled per lane (index = ptr + lane, mod `DEPTH`).
- Asynchronous reset mid-operation clears state immediately; the outputs show reset values while `rst_n` = 0.

## Test plan
- **Reset, then single push:** push one uop (tag 0xA1) on lane 0 → next cycle `all_uop_cnt` = 1, `fifo_empty_rs2ex` = 0, `fifo_almost_empty_rs2ex` = 2'b10, `pmtrdt_uop_rs2ex[0]` tag = 0xA1.
- **Fill to full:** push 2 per cycle for 4 cycles (`DEPTH` = 8) → `all_uop_cnt` = 8, `push_ready_rs2dp` = 2'b00, `all_uop_data[0..7]` in push order. A fifth push is not accepted.
- **Full with simultaneous push and pop:** at `cnt` = 8, pop 2 with push valid 2'b11 → `cnt` = 6 next cycle and the push is ignored. The following cycle, the push is accepted and `cnt` = 8.
- **Wraparound:** with rptr = wptr = 7 and `cnt` = 0, push 2 → entries land at indices 7 and 0. Pop 2 over the following cycles → lanes 0 and 1 return them in order, and `cnt` = 0.
- **Flush priority:** with `cnt` = 5, assert `trap_flush_rvv` together with push 2 and pop 1 → next cycle `cnt` = 0, `fifo_empty_rs2ex` = 1, `push_ready_rs2dp` = 2'b11.
- **Async reset mid-stream:** drop `rst_n` between edges at `cnt` = 3 → the outputs go to reset values immediately, without waiting for a clock edge.
